// File: rtl/qadd.sv
// Registered signed adder/subtractor at 2*DWIDTH bits with optional saturation,
// per-result overflow and a sticky overflow flag that ovf_clr clears.
module qadd #(
  parameter int DWIDTH   = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  sub,
  input  logic [2*DWIDTH-1:0]   a,
  input  logic [2*DWIDTH-1:0]   b,
  input  logic                  ovf_clr,
  output logic [2*DWIDTH-1:0]   c,
  output logic                  out_valid,
  output logic                  ovf,
  output logic                  ovf_sticky
);

  localparam int W = 2 * DWIDTH;

  logic [W:0]   a_ext, b_ext, s;
  logic         ovf_int;
  logic [W-1:0] c_d;
  logic [W-1:0] c_q;
  logic         out_valid_q, ovf_q, ovf_sticky_q;

  // One extra bit keeps the exact sum, including a - (-2^(W-1)).
  always_comb begin
    a_ext   = {a[W-1], a};
    b_ext   = {b[W-1], b};
    s       = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf_int = s[W] ^ s[W-1];
    c_d     = s[W-1:0];
    if (SATURATE && ovf_int) begin
      c_d = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q          <= '0;
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        c_q   <= c_d;
        ovf_q <= ovf_int;
      end
      // A new overflow takes priority over a simultaneous clear.
      if (in_valid && ovf_int) begin
        ovf_sticky_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky_q <= 1'b0;
      end
    end
  end

  assign c          = c_q;
  assign out_valid  = out_valid_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_qadd.sv
// Self-checking bench for qadd: saturating and wrapping instances share stimulus
// and are compared against an integer-arithmetic reference model.
module tb_qadd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ovf_clr = 1'b0;

  logic [15:0] c_s, c_w;
  logic        ov_s, ov_w, ovf_s, ovf_w, st_s, st_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_cs, exp_cw;
  logic        exp_v, exp_ovf, exp_st;

  always #5 clk = ~clk;

  qadd #(.DWIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .ovf_clr(ovf_clr), .c(c_s), .out_valid(ov_s), .ovf(ovf_s), .ovf_sticky(st_s)
  );

  qadd #(.DWIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .ovf_clr(ovf_clr), .c(c_w), .out_valid(ov_w), .ovf(ovf_w), .ovf_sticky(st_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".c_sat"},   32'(c_s),   32'(exp_cs));
    check({tag, ".c_wrap"},  32'(c_w),   32'(exp_cw));
    check({tag, ".valid"},   32'(ov_s),  32'(exp_v));
    check({tag, ".valid_w"}, 32'(ov_w),  32'(exp_v));
    check({tag, ".ovf"},     32'(ovf_s), 32'(exp_ovf));
    check({tag, ".ovf_w"},   32'(ovf_w), 32'(exp_ovf));
    check({tag, ".sticky"},  32'(st_s),  32'(exp_st));
    check({tag, ".sticky_w"},32'(st_w),  32'(exp_st));
  endtask

  // Reference: exact integer sum, range test, then clamp or wrap.
  task automatic model(input logic [15:0] va, input logic [15:0] vb,
                       input logic vsub, input logic vvalid, input logic vclr);
    int ia, ib, sum;
    logic ov;
    ia  = $signed(va);
    ib  = $signed(vb);
    sum = vsub ? ia - ib : ia + ib;
    ov  = (sum > 32767) || (sum < -32768);
    exp_v = vvalid;
    if (vvalid) begin
      exp_ovf = ov;
      exp_cw  = sum[15:0];
      if (sum > 32767)       exp_cs = 16'h7FFF;
      else if (sum < -32768) exp_cs = 16'h8000;
      else                   exp_cs = sum[15:0];
    end
    if (vvalid && ov) exp_st = 1'b1;
    else if (vclr)    exp_st = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vsub, input logic vvalid, input logic vclr);
    @(negedge clk);
    a = va; b = vb; sub = vsub; in_valid = vvalid; ovf_clr = vclr;
    @(posedge clk);
    model(va, vb, vsub, vvalid, vclr);
    #1;
    check_all(tag);
  endtask

  task automatic reset_model();
    exp_cs = '0; exp_cw = '0; exp_v = 1'b0; exp_ovf = 1'b0; exp_st = 1'b0;
  endtask

  initial begin
    reset_model();
    #2;
    check_all("reset");
    in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    do_op("basic_add",  16'h1000, 16'h0234, 1'b0, 1'b1, 1'b0);
    do_op("pos_sat",    16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    do_op("idle_hold",  16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    do_op("neg_sat",    16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    do_op("clr_alone",  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    do_op("sub_minneg", 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b0);
    do_op("clr_and_ov", 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    do_op("sub_small",  16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    do_op("sub_minmin", 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0);
    do_op("max_plus_n", 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op("min_sub_1",  16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);

    // In-range sweep: never overflows, so sticky must stay at its current value.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($signed($urandom_range(16382)) - 8191);
      rb = 16'($signed($urandom_range(16382)) - 8191);
      do_op("sweep", ra, rb, 1'($urandom_range(1)), 1'b1, 1'b0);
    end

    for (int i = 0; i < 300; i++) begin
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(1)),
            ($urandom_range(3) != 0), ($urandom_range(7) == 0));
    end

    // Asynchronous reset mid-cycle, away from any clock edge.
    do_op("pre_rst", 16'h7FFF, 16'h0100, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    check_all("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    do_op("post_rst", 16'h0123, 16'h0001, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qadd.md
Name: qadd

Overview:
- Signed two's-complement fixed-point adder/subtractor for the TPU pooling datapath.
- Operands and result are 2*DWIDTH bits wide, matching the accumulator width of DWIDTH-bit products.
- Output is registered, optionally saturating, and reports overflow per result and as a sticky flag.
- Feeds pooling and accumulation stages.

Parameters:
- DWIDTH, 8, base data width; operand/result width W = 2*DWIDTH (16 by default).
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- sub  input  1  0: c = a + b; 1: c = a - b.
- a  input  W  signed operand.
- b  input  W  signed operand.
- ovf_clr  input  1  synchronous clear of ovf_sticky.
- c  output  W  signed result (registered).
- out_valid  output  1  c valid.
- ovf  output  1  overflow on the result currently on c.
- ovf_sticky  output  1  set by any overflowing valid op, held until cleared.

Behaviour:
- Reset (rst_n low, asynchronous, any time): c = 0, out_valid = 0, ovf = 0, ovf_sticky = 0. Outputs hold these values while rst_n is low.
- Reset release: takes effect at the first rising clk edge after rst_n goes high. An in_valid asserted during reset is discarded.
- Latency and throughput:
  - Exactly 1 cycle. Operands sampled at edge N appear on c/ovf with out_valid = 1 after edge N.
  - Full throughput, one op per cycle, no backpressure.
- Idle cycles: when in_valid = 0 at an edge, out_valid goes 0. c and ovf hold their previous values.
- Arithmetic:
  - Sign-extend a and b to W+1 bits; compute s = a + b, or s = a - b when sub = 1, at W+1 bits. No truncation before the overflow check.
  - b = -2^(W-1) with sub = 1 is handled exactly via the extended width.
- Overflow: ovf_int = (s[W] != s[W-1]), i.e. the true result lies outside [-2^(W-1), 2^(W-1)-1].
- Result selection:
  - SATURATE = 1: on overflow, c = 0x7FFF (max) if s is positive, or 0x8000 (min) if negative. Otherwise c = s[W-1:0].
  - SATURATE = 0: c = s[W-1:0] (wrap); ovf is still reported.
- ovf is registered with c and is only meaningful when out_valid = 1.
- ovf_sticky:
  - Set on any edge where in_valid = 1 and ovf_int = 1.
  - Cleared at an edge when ovf_clr = 1.
  - If ovf_clr and a new overflow occur at the same edge, set wins (the flag stays 1).
- Purely signed arithmetic; no rounding, no fractional-point shifting (the binary point is identical for a, b and c).

Test Plan:
- Basic add: a = 0x1000, b = 0x0234, sub = 0 -> c = 0x1234, ovf = 0, out_valid = 1 one cycle later.
- Positive saturate: a = 0x7FFF, b = 0x0001 -> c = 0x7FFF, ovf = 1, ovf_sticky = 1. With SATURATE = 0: c = 0x8000, ovf = 1.
- Negative saturate: a = 0x8000, b = 0xFFFF -> c = 0x8000, ovf = 1.
- Subtract edge case: a = 0x0000, b = 0x8000, sub = 1 -> c = 0x7FFF, ovf = 1. a = 0x0005, b = 0x0007, sub = 1 -> c = 0xFFFE, ovf = 0.
- Random sweep: 10+ back-to-back ops with a and b drawn from (-8192, 8192), in_valid = 1 -> c equals the exact sum every cycle, ovf = 0, ovf_sticky unchanged.
- Reset and sticky behaviour:
  - Assert rst_n = 0 mid-stream -> c = 0, out_valid = 0, ovf_sticky = 0 immediately, without a clock edge.
  - ovf_clr = 1 alone -> ovf_sticky = 0 next cycle.
  - ovf_clr = 1 together with an overflowing op -> ovf_sticky stays 1.
